// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared defaults and entry type for the store buffer
package store_buffer_pkg;

   localparam int SB_DEPTH = 4;
   localparam int SB_AW    = 32;
   localparam int SB_DW    = 32;

   typedef struct packed {
      logic [SB_AW-1:0] addr;
      logic [SB_DW-1:0] data;
   } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// rtl/sb_fwd_match.sv - word-address match of a load against occupied entries, youngest wins
module sb_fwd_match
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int AW    = SB_AW,
   parameter int DW    = SB_DW,
   parameter int PW    = $clog2(DEPTH),
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  sb_entry_t        i_entries [DEPTH],
   input  logic [PW-1:0]    i_rd_ptr,
   input  logic [CW-1:0]    i_count,
   input  logic [AW-1:0]    i_ld_addr,
   output logic             o_hit,
   output logic [DW-1:0]    o_data
);

   logic [PW-1:0] w_idx;

   // Walk oldest to youngest so the last match written is the youngest one.
   always_comb begin
      o_hit  = 1'b0;
      o_data = '0;
      w_idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = i_rd_ptr + PW'(k);
         if ((CW'(k) < i_count) &&
             (((i_entries[w_idx].addr ^ i_ld_addr) & ~AW'(3)) == '0)) begin
            o_hit  = 1'b1;
            o_data = i_entries[w_idx].data;
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store FIFO between core and data bus with load forwarding
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int AW    = SB_AW,
   parameter int DW    = SB_DW
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   st_valid,
   input  logic [AW-1:0]          st_addr,
   input  logic [DW-1:0]          st_data,
   output logic                   st_stall,
   input  logic [AW-1:0]          ld_addr,
   output logic                   ld_hit,
   output logic [DW-1:0]          ld_data,
   output logic                   bus_valid,
   output logic [AW-1:0]          bus_addr,
   output logic [DW-1:0]          bus_data,
   input  logic                   bus_ready,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   sb_entry_t     r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic w_full;
   logic w_enq;
   logic w_deq;

   assign w_full    = (r_count == CW'(DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign bus_valid = ~empty;
   assign w_deq     = bus_valid & bus_ready;
   // A drain in the same cycle frees the slot a full-FIFO store needs.
   assign st_stall  = st_valid & w_full & ~w_deq;
   assign w_enq     = st_valid & ~st_stall;

   assign bus_addr  = r_mem[r_rd_ptr].addr & ~AW'(3);
   assign bus_data  = r_mem[r_rd_ptr].data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload needs no reset: count alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (w_enq) r_mem[r_wr_ptr] <= '{addr: st_addr, data: st_data};
   end

   sb_fwd_match #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_fwd (
      .i_entries (r_mem),
      .i_rd_ptr  (r_rd_ptr),
      .i_count   (r_count),
      .i_ld_addr (ld_addr),
      .o_hit     (ld_hit),
      .o_data    (ld_data)
   );

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - scoreboard bench for store_buffer
module tb_store_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        st_valid;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        st_stall;
   logic [31:0] ld_addr;
   logic        ld_hit;
   logic [31:0] ld_data;
   logic        bus_valid;
   logic [31:0] bus_addr;
   logic [31:0] bus_data;
   logic        bus_ready;
   logic [2:0]  count;
   logic        empty;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } exp_t;

   exp_t exp_q[$];
   exp_t m_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .st_valid  (st_valid),
      .st_addr   (st_addr),
      .st_data   (st_data),
      .st_stall  (st_stall),
      .ld_addr   (ld_addr),
      .ld_hit    (ld_hit),
      .ld_data   (ld_data),
      .bus_valid (bus_valid),
      .bus_addr  (bus_addr),
      .bus_data  (bus_data),
      .bus_ready (bus_ready),
      .count     (count),
      .empty     (empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One store attempt; pushes the expectation only when the store is accepted.
   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic exp_stall, input string name);
      st_valid = 1'b1;
      st_addr  = a;
      st_data  = d;
      @(negedge clk);
      chk(name, 32'(st_stall), 32'(exp_stall));
      if (!st_stall) exp_q.push_back('{a: a, d: d});
      cyc();
      st_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst_n && bus_valid && bus_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL mon_unexpected: got bus request addr %0h, expected none", bus_addr);
         end else begin
            m_e = exp_q.pop_front();
            chk("mon_addr", bus_addr, m_e.a & ~32'h3);
            chk("mon_data", bus_data, m_e.d);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      st_valid  = 1'b0;
      st_addr   = '0;
      st_data   = '0;
      ld_addr   = '0;
      bus_ready = 1'b0;
      #2;
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_bus_valid", 32'(bus_valid), 0);
      chk("rst_ld_hit", 32'(ld_hit), 0);
      chk("rst_st_stall", 32'(st_stall), 0);
      cyc();
      rst_n = 1'b1;
      cyc();

      // single store, no same-cycle bypass
      bus_ready = 1'b1;
      st_valid  = 1'b1;
      st_addr   = 32'd100;
      st_data   = 32'd25;
      @(negedge clk);
      chk("single_nobypass", 32'(bus_valid), 0);
      chk("single_stall", 32'(st_stall), 0);
      exp_q.push_back('{a: 32'd100, d: 32'd25});
      cyc();
      st_valid = 1'b0;
      @(negedge clk);
      chk("single_bus_valid", 32'(bus_valid), 1);
      chk("single_bus_addr", bus_addr, 32'd100);
      chk("single_bus_data", bus_data, 32'd25);
      chk("single_count1", 32'(count), 1);
      cyc();
      @(negedge clk);
      chk("single_count0", 32'(count), 0);
      chk("single_empty", 32'(empty), 1);
      cyc();

      // fill, stall, drain in order
      bus_ready = 1'b0;
      for (int i = 0; i < 4; i++) store(32'h60 + 32'(4 * i), 32'(i + 1), 1'b0, "fill_stall");
      @(negedge clk);
      chk("fill_count4", 32'(count), 4);
      chk("fill_head_addr", bus_addr, 32'h60);
      cyc();
      store(32'h70, 32'hDEAD, 1'b1, "fill_fifth_stall");
      @(negedge clk);
      chk("fill_count_after_stall", 32'(count), 4);
      cyc();
      bus_ready = 1'b1;
      repeat (4) cyc();
      bus_ready = 1'b0;
      @(negedge clk);
      chk("drain_empty", 32'(empty), 1);
      cyc();

      // full plus simultaneous drain
      for (int i = 0; i < 4; i++) store(32'h80 + 32'(4 * i), 32'(16 + i), 1'b0, "full2_fill");
      bus_ready = 1'b1;
      store(32'h90, 32'h55, 1'b0, "full_drain_stall");
      bus_ready = 1'b0;
      @(negedge clk);
      chk("full_drain_count", 32'(count), 4);
      cyc();
      bus_ready = 1'b1;
      repeat (4) cyc();
      bus_ready = 1'b0;
      @(negedge clk);
      chk("full_drain_empty", 32'(empty), 1);
      cyc();

      // forwarding: enqueue not forwarded, youngest wins, dequeue still forwarded
      ld_addr = 32'h62;
      st_valid = 1'b1;
      st_addr  = 32'h60;
      st_data  = 32'd7;
      @(negedge clk);
      chk("fwd_enq_nohit", 32'(ld_hit), 0);
      exp_q.push_back('{a: 32'h60, d: 32'd7});
      cyc();
      st_data = 32'd9;
      @(negedge clk);
      chk("fwd_enq_old_hit", 32'(ld_hit), 1);
      chk("fwd_enq_old_data", ld_data, 32'd7);
      exp_q.push_back('{a: 32'h60, d: 32'd9});
      cyc();
      st_valid = 1'b0;
      @(negedge clk);
      chk("fwd_young_hit", 32'(ld_hit), 1);
      chk("fwd_young_data", ld_data, 32'd9);
      ld_addr = 32'h64;
      #1;
      chk("fwd_miss_hit", 32'(ld_hit), 0);
      chk("fwd_miss_data", ld_data, 0);
      ld_addr = 32'h62;
      cyc();
      bus_ready = 1'b1;
      @(negedge clk);
      chk("fwd_deq_data", ld_data, 32'd9);
      cyc();
      @(negedge clk);
      chk("fwd_last_hit", 32'(ld_hit), 1);
      chk("fwd_last_data", ld_data, 32'd9);
      cyc();
      @(negedge clk);
      chk("fwd_gone_hit", 32'(ld_hit), 0);
      cyc();

      // backpressure hold, low address bits dropped on the bus
      bus_ready = 1'b0;
      store(32'h107, 32'hABCD, 1'b0, "bp_stall");
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("bp_hold_addr", bus_addr, 32'h104);
         chk("bp_hold_data", bus_data, 32'hABCD);
         cyc();
      end
      bus_ready = 1'b1;
      cyc();
      @(negedge clk);
      chk("bp_done_empty", 32'(empty), 1);
      cyc();

      // asynchronous reset mid-operation
      bus_ready = 1'b0;
      for (int i = 0; i < 3; i++) store(32'h200 + 32'(4 * i), 32'(i + 40), 1'b0, "rst_mid_fill");
      @(negedge clk);
      chk("rst_mid_count3", 32'(count), 3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_bus_valid", 32'(bus_valid), 0);
      chk("rst_mid_count", 32'(count), 0);
      chk("rst_mid_empty", 32'(empty), 1);
      exp_q.delete();
      bus_ready = 1'b1;
      cyc();
      rst_n = 1'b1;
      repeat (2) cyc();
      @(negedge clk);
      chk("rst_mid_after_empty", 32'(empty), 1);
      cyc();

      chk("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
